// File: rtl/adc_spi_sim_mc.sv
// adc_spi_sim_mc: clock-synchronous model of a multi-channel sigma-delta ADC with an SPI slave
// (mode 3) and a combined DOUT/RDY pin.
// Optional feature macro: ADC_SIM_NOISE_EN (16-bit LFSR noise XORed into DATA[3:0]).
// Ports:
//   clk        model clock (>= 4x SCLK rate)
//   rst        synchronous active-high reset
//   CS         SPI chip select, active low
//   SCLK       SPI clock, idles high; slave drives on falling, master samples on rising
//   DIN        serial data into the model
//   DOUT_RDY   serial data out / active-low ready flag; z while CS is high
//   conv_count number of completed conversions (wraps at 16 bits)
//   xfer_done  one-cycle pulse when a full register transfer completes
module adc_spi_sim_mc #(
    parameter int DW          = 24,
    parameter int NCH         = 6,
    parameter int CONV_CYCLES = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        DIN,
    output logic        DOUT_RDY,
    output logic [15:0] conv_count,
    output logic        xfer_done
);
    typedef enum logic [2:0] {IDLE, CMD, WR, RD, DONE} state_t;
    localparam int TW = $clog2(CONV_CYCLES);

    logic [SYNC_STAGES-1:0] cs_q, sclk_q, din_q;
    logic                   cs_s, sclk_s, din_s, sclk_d, rise, fall;
    state_t                 state, state_n;
    logic [6:0]             cmd_sh;
    logic [7:0]             cb;
    logic [31:0]            sh, ld_val;
    logic [5:0]             bcnt, ld_w;
    logic [2:0]             addr, ld_a;
    logic                   so, go_wr, go_rd, wr_fire, rd_fire;
    logic [1:0]             mode;
    logic [3:0]             chan;
    logic [DW-1:0]          data, samp;
    logic                   rdy_n, conv_in_rd, mode_w, cfg_w, tc, conv;
    logic [TW-1:0]          timer;
    logic [DW-5:0]          cnt [NCH];
    logic [DW-5:0]          cur;

    function automatic logic [5:0] width_of(input logic [2:0] a);
        return a == 3'd0 ? 6'd8 : a == 3'd3 ? 6'(DW) : 6'd16;
    endfunction

    // Plain shift-register synchronisers; reset to the bus idle levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= '1;
            sclk_q <= '1;
            din_q  <= '0;
            sclk_d <= 1'b1;
        end else begin
            cs_q   <= (cs_q << 1) | SYNC_STAGES'(CS);
            sclk_q <= (sclk_q << 1) | SYNC_STAGES'(SCLK);
            din_q  <= (din_q << 1) | SYNC_STAGES'(DIN);
            sclk_d <= sclk_s;
        end
    end

    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign din_s  = din_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;
    assign cb     = {cmd_sh, din_s};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Command byte is a sliding window: once 8 bits are in, every new bit re-evaluates
    // the last 8 until WEN (bit 7) reads 0.
    always_comb begin
        state_n = state;
        go_wr   = 1'b0;
        go_rd   = 1'b0;
        wr_fire = 1'b0;
        rd_fire = 1'b0;
        if (cs_s) state_n = IDLE;
        else begin
            case (state)
                IDLE: state_n = CMD;
                CMD: if (rise && bcnt == 6'd7 && !cb[7]) begin
                    go_rd   = cb[6];
                    go_wr   = !cb[6];
                    state_n = cb[6] ? RD : WR;
                end
                WR: if (rise && bcnt == 6'd15) begin
                    wr_fire = 1'b1;
                    state_n = DONE;
                end
                RD: if (rise && bcnt == width_of(addr) - 6'd1) begin
                    rd_fire = 1'b1;
                    state_n = DONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_a   = cb[5:3];
        ld_w   = width_of(ld_a);
        ld_val = ld_a == 3'd0 ? {24'b0, rdy_n, 3'b0, chan} :
                 ld_a == 3'd1 ? {30'b0, mode} :
                 ld_a == 3'd2 ? {28'b0, chan} :
                 ld_a == 3'd3 ? 32'(data) : 32'b0;
    end

    // Shift register is left-aligned so the MSB of any width always sits at bit 31.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            bcnt   <= '0;
            cmd_sh <= '0;
            so     <= 1'b0;
            addr   <= '0;
            sh     <= '0;
        end else begin
            if (go_wr || go_rd) begin
                addr <= ld_a;
                bcnt <= '0;
            end else if (rise && state != DONE)
                bcnt <= (state == CMD && bcnt == 6'd7) ? bcnt : bcnt + 6'd1;
            if (rise && state == CMD) cmd_sh <= cb[6:0];
            if (go_rd) sh <= ld_val << (7'd32 - {1'b0, ld_w});
            else if (rise && state == WR) sh <= {sh[30:0], din_s};
            else if (fall && state == RD) begin
                so <= sh[31];
                sh <= {sh[30:0], 1'b0};
            end
        end
    end

    assign mode_w = wr_fire && addr == 3'd1;
    assign cfg_w  = wr_fire && addr == 3'd2;
    assign tc     = !mode[1] && timer == TW'(CONV_CYCLES - 1);
    // A register write restarts the timer, so it suppresses a coincident conversion.
    assign conv   = tc && !(mode_w || cfg_w);

    always_comb begin
        cur = '0;
        for (int k = 0; k < NCH; k++)
            if (chan == 4'(k)) cur = cnt[k];
    end

`ifdef ADC_SIM_NOISE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst)       lfsr <= 16'hACE1;
        else if (conv) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign samp = {chan, cur} ^ DW'(lfsr[3:0]);
`else
    assign samp = {chan, cur};
`endif

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++)
            if (rst) cnt[k] <= '0;
            else if (conv && chan == 4'(k)) cnt[k] <= cnt[k] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= 2'd2;
            chan       <= '0;
            data       <= '0;
            rdy_n      <= 1'b1;
            timer      <= '0;
            conv_count <= '0;
            conv_in_rd <= 1'b0;
            xfer_done  <= 1'b0;
        end else begin
            xfer_done  <= wr_fire | rd_fire;
            timer      <= (mode_w || cfg_w || tc || mode[1]) ? '0 : timer + 1'b1;
            mode       <= mode_w ? {sh[0], din_s} : (conv && mode == 2'd1) ? 2'd2 : mode;
            if (cfg_w)
                chan <= {1'b0, sh[2:0], din_s} >= 5'(NCH) ? 4'(NCH - 1) : {sh[2:0], din_s};
            if (conv) begin
                data       <= samp;
                conv_count <= conv_count + 16'd1;
            end
            // A conversion landing inside a DATA read keeps the ready flag low after it ends.
            conv_in_rd <= state == RD && addr == 3'd3 && (conv_in_rd || conv);
            rdy_n      <= (mode_w || cfg_w) ? 1'b1 :
                          conv ? 1'b0 :
                          (rd_fire && addr == 3'd3 && !conv_in_rd) ? 1'b1 : rdy_n;
        end
    end

    assign DOUT_RDY = state == IDLE ? 1'bz :
                      state == CMD  ? rdy_n :
                      state == RD   ? so : 1'b0;
endmodule
